barrier_check: RTL and testbench
================================

# barrier_check

Consumer end of the barrier column stream. `startColumn` injects a new 8-light barrier pattern at the entry edge of the field. This block samples the pattern that has scrolled into the bird's column and compares it, every cycle, against the bird's one-hot row. It latches a crash, counts cleanly passed barriers as a two-digit BCD score for the HEX displays, and holds the game-state FSM that freezes play after a crash.

## Interface
Parameters:
- ROWS, 8, number of lights per column; the bird and column vectors are ROWS wide.
- SCORE_MAX, 99, saturation value for the BCD score; legal range 1..99.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; all state clears while low.
- start  input  1  one-cycle pulse (already debounced upstream); begins a game from IDLE or OVER.
- advance  input  1  one-cycle scroll tick, the same tick that shifts columns across the field.
- col_in  input  ROWS  column arriving at the bird's position; bit ROWS-1 is the top light (light8) and bit 0 is the bottom light (light1); 1 = barrier.
- bird  input  ROWS  bird position; one-hot in normal play, all-zero means the bird has left the field.
- playing  output  1  high in RUN and PASS.
- crash  output  1  high in OVER.
- score_tens  output  4  BCD tens digit.
- score_ones  output  4  BCD ones digit.

## Operation
- Internal register cur_col[ROWS-1:0] holds the column currently at the bird. It loads col_in on every cycle where advance=1 and state is RUN or PASS. It is cleared on start.
- hit = (cur_col & bird) != 0, or bird == 0. hit is evaluated every cycle, not only on advance, so a bird that moves into a barrier mid-column still crashes.
- FSM states and transitions:
  - IDLE: entered on reset. start → RUN. All other inputs are ignored.
  - RUN: cur_col == 0. hit (bird==0 only) → OVER. advance with col_in != 0 → PASS. Otherwise stay in RUN.
  - PASS: cur_col != 0.
    - hit → OVER, with no score change.
    - advance with no hit → score += 1, and cur_col loads col_in. Next state is PASS if col_in != 0, else RUN.
  - OVER: cur_col and score are frozen. start → RUN, with score cleared to 00 and cur_col cleared. advance is ignored.
- Priority within a cycle: hit > advance > start, except in IDLE and OVER, where only start is acted on.
- Score arithmetic: BCD increment. When ones = 9 it wraps to 0 and tens increments. When tens:ones equals SCORE_MAX the score holds; there is no wrap to 00.
- Back-to-back barrier columns: each advance that leaves PASS without a hit scores once. A 3-column-wide barrier therefore scores 3.
- bird not one-hot with more than one bit set: treated as-is. Any overlap with cur_col is a hit.

## Timing
- Reset values: state=IDLE, cur_col=0, playing=0, crash=0, score_tens=0, score_ones=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A column presented with advance at edge N is in cur_col after N. A collision with it raises crash after edge N+1 at the earliest; hit latency is 1 cycle after cur_col/bird overlap appears.
- A score increment is visible the cycle after the scoring advance edge.
- playing falls in the same cycle crash rises.
- start from OVER: crash=0, playing=1 and score=00 are all visible after a single edge.
- reset asserted mid-game returns all outputs to reset values immediately (asynchronous). On release, the block stays in IDLE until the next start.

## Test plan
- Reset and idle: hold reset low, then release; pulse advance 5 times with col_in=8'b11100011 and bird=8'b00001000 → playing=0, crash=0, score stays 00.
- Clean pass: start; advance with col_in=8'b11100011 and bird=8'b00001000; then advance with col_in=0 → state goes PASS then RUN, score=01, crash=0 throughout.
- Collision: start; bird=8'b00000001; advance with col_in=8'b11110001 → crash=1 and playing=0 one cycle after cur_col loads; further advances leave score=00.
- Mid-column move: in PASS with cur_col=8'b11000111 and bird=8'b00010000 (safe), change bird to 8'b00000100 with no advance → crash=1 on the next edge. Hit and advance in the same cycle → OVER, score unchanged.
- Score rollover and saturation: run 9 clean passes → score=09, then one more → score=10. With SCORE_MAX=12, 15 clean passes → score holds at 12.
- Restart and async reset: from OVER with score=07, pulse start → crash=0, playing=1, score=00. Then drop reset between clock edges → all outputs clear before the next edge.

Source files
------------

// File: rtl/barrier_check.sv
// Bird-column collision checker: samples the column at the bird, latches crashes,
// and keeps a saturating two-digit BCD score of cleanly passed barrier columns.
module barrier_check #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            advance,
  input  logic [ROWS-1:0] col_in,
  input  logic [ROWS-1:0] bird,
  output logic            playing,
  output logic            crash,
  output logic [3:0]      score_tens,
  output logic [3:0]      score_ones
);

  localparam logic [3:0] MAX_TENS = 4'(SCORE_MAX / 10);
  localparam logic [3:0] MAX_ONES = 4'(SCORE_MAX % 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [ROWS-1:0] cur_col_q, cur_col_d;
  logic [3:0]      tens_d, ones_d;
  logic            hit;
  logic            at_max;

  // A bird that has left the field counts as a collision.
  assign hit    = (|(cur_col_q & bird)) || !(|bird);
  assign at_max = (score_tens == MAX_TENS) && (score_ones == MAX_ONES);

  // Next-state, column capture and BCD score update.
  always_comb begin
    state_d   = state_q;
    cur_col_d = cur_col_q;
    tens_d    = score_tens;
    ones_d    = score_ones;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d   = S_RUN;
          cur_col_d = '0;
          tens_d    = 4'd0;
          ones_d    = 4'd0;
        end
      end
      S_RUN, S_PASS: begin
        if (hit) begin
          state_d = S_OVER;
        end else if (advance) begin
          cur_col_d = col_in;
          state_d   = (|col_in) ? S_PASS : S_RUN;
          if (state_q == S_PASS && !at_max) begin
            if (score_ones == 4'd9) begin
              ones_d = 4'd0;
              tens_d = score_tens + 4'd1;
            end else begin
              ones_d = score_ones + 4'd1;
            end
          end
        end else if (start) begin
          state_d   = S_RUN;
          cur_col_d = '0;
          tens_d    = 4'd0;
          ones_d    = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, column and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cur_col_q  <= '0;
      score_tens <= 4'd0;
      score_ones <= 4'd0;
      playing    <= 1'b0;
      crash      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_col_q  <= cur_col_d;
      score_tens <= tens_d;
      score_ones <= ones_d;
      playing    <= (state_d == S_RUN) || (state_d == S_PASS);
      crash      <= (state_d == S_OVER);
    end
  end

endmodule

// File: tb/tb_barrier_check.sv
// Scoreboard bench for barrier_check: a default instance and a SCORE_MAX=12
// instance share stimulus; expected outputs are queued per cycle and compared.
module tb_barrier_check;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       advance;
  logic [7:0] col_in;
  logic [7:0] bird;
  logic       playing_a, crash_a, playing_b, crash_b;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       playing;
    logic       crash;
    logic [3:0] tens;
    logic [3:0] ones;
  } exp_t;

  exp_t exp_q[2][$];

  // Behavioural model: 0 idle, 1 run, 2 pass, 3 over
  int         m_state[2];
  logic [7:0] m_col[2];
  int         m_score[2];
  int         m_max[2] = '{99, 12};

  barrier_check dut_a (
    .clk(clk), .reset(reset), .start(start), .advance(advance),
    .col_in(col_in), .bird(bird), .playing(playing_a), .crash(crash_a),
    .score_tens(tens_a), .score_ones(ones_a)
  );

  barrier_check #(.ROWS(8), .SCORE_MAX(12)) dut_b (
    .clk(clk), .reset(reset), .start(start), .advance(advance),
    .col_in(col_in), .bird(bird), .playing(playing_b), .crash(crash_b),
    .score_tens(tens_b), .score_ones(ones_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_col[i]   = 8'h00;
      m_score[i] = 0;
      exp_q[i].delete();
    end
  endtask

  task automatic model_step();
    bit hit;
    for (int i = 0; i < 2; i++) begin
      hit = ((m_col[i] & bird) != 8'h00) || (bird == 8'h00);
      if (m_state[i] == 0 || m_state[i] == 3) begin
        if (start) begin
          m_state[i] = 1; m_col[i] = 8'h00; m_score[i] = 0;
        end
      end else if (hit) begin
        m_state[i] = 3;
      end else if (advance) begin
        if (m_state[i] == 2 && m_score[i] < m_max[i]) m_score[i]++;
        m_col[i]   = col_in;
        m_state[i] = (col_in != 8'h00) ? 2 : 1;
      end else if (start) begin
        m_state[i] = 1; m_col[i] = 8'h00; m_score[i] = 0;
      end
    end
  endtask

  function automatic exp_t model_out(input int i);
    exp_t e;
    e.playing = (m_state[i] == 1 || m_state[i] == 2);
    e.crash   = (m_state[i] == 3);
    e.tens    = 4'(m_score[i] / 10);
    e.ones    = 4'(m_score[i] % 10);
    return e;
  endfunction

  // One clock: drive inputs just after an edge, queue expectations, compare after next edge.
  task automatic cyc(input logic st, input logic adv, input logic [7:0] col, input logic [7:0] b);
    exp_t e;
    start = st; advance = adv; col_in = col; bird = b;
    model_step();
    for (int i = 0; i < 2; i++) exp_q[i].push_back(model_out(i));
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (exp_q[i].size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        e = exp_q[i].pop_front();
        if (i == 0) begin
          chk("a_playing", int'(playing_a), int'(e.playing));
          chk("a_crash",   int'(crash_a),   int'(e.crash));
          chk("a_tens",    int'(tens_a),    int'(e.tens));
          chk("a_ones",    int'(ones_a),    int'(e.ones));
        end else begin
          chk("b_playing", int'(playing_b), int'(e.playing));
          chk("b_crash",   int'(crash_b),   int'(e.crash));
          chk("b_tens",    int'(tens_b),    int'(e.tens));
          chk("b_ones",    int'(ones_b),    int'(e.ones));
        end
      end
    end
    start = 1'b0; advance = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    chk("rst_playing", int'(playing_a), 0);
    chk("rst_crash",   int'(crash_a),   0);
    chk("rst_score",   int'({tens_a, ones_a}), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic clean_pass(input logic [7:0] b);
    cyc(1'b0, 1'b1, 8'b11100011, b);
    cyc(1'b0, 1'b1, 8'b00000000, b);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; advance = 1'b0; col_in = 8'h00; bird = 8'b00001000;
    @(posedge clk);
    #1;
    do_reset();

    // Idle ignores advance
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 8'b11100011, 8'b00001000);
    chk("idle_playing", int'(playing_a), 0);
    chk("idle_score", int'({tens_a, ones_a}), 0);

    // Clean pass scores once
    cyc(1'b1, 1'b0, 8'h00, 8'b00001000);
    chk("start_playing", int'(playing_a), 1);
    clean_pass(8'b00001000);
    chk("pass_score", int'({tens_a, ones_a}), 8'h01);
    chk("pass_crash", int'(crash_a), 0);

    // Collision one cycle after the column loads
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 8'b00000001);
    cyc(1'b0, 1'b1, 8'b11110001, 8'b00000001);
    chk("coll_not_yet", int'(crash_a), 0);
    cyc(1'b0, 1'b0, 8'h00, 8'b00000001);
    chk("coll_crash", int'(crash_a), 1);
    chk("coll_playing", int'(playing_a), 0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 8'b11100011, 8'b00001000);
    chk("coll_score", int'({tens_a, ones_a}), 0);

    // Bird moves into the barrier mid-column
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 8'b00010000);
    cyc(1'b0, 1'b1, 8'b11000111, 8'b00010000);
    cyc(1'b0, 1'b0, 8'h00, 8'b00010000);
    chk("mid_safe", int'(playing_a), 1);
    cyc(1'b0, 1'b0, 8'h00, 8'b00000100);
    chk("mid_crash", int'(crash_a), 1);

    // Hit and advance together: crash wins, no score
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 8'b00010000);
    cyc(1'b0, 1'b1, 8'b11000111, 8'b00010000);
    cyc(1'b0, 1'b1, 8'h00, 8'b00000100);
    chk("hitadv_crash", int'(crash_a), 1);
    chk("hitadv_score", int'({tens_a, ones_a}), 0);

    // Rollover and saturation
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 8'b00001000);
    for (int k = 0; k < 9; k++) clean_pass(8'b00001000);
    chk("roll_09", int'({tens_a, ones_a}), 8'h09);
    clean_pass(8'b00001000);
    chk("roll_10", int'({tens_a, ones_a}), 8'h10);
    for (int k = 0; k < 5; k++) clean_pass(8'b00001000);
    chk("sat12_b", int'({tens_b, ones_b}), 8'h12);
    chk("nosat_a", int'({tens_a, ones_a}), 8'h15);
    for (int k = 0; k < 85; k++) clean_pass(8'b00001000);
    chk("sat99_a", int'({tens_a, ones_a}), 8'h99);

    // Restart from OVER with score 07
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 8'b00001000);
    for (int k = 0; k < 7; k++) clean_pass(8'b00001000);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    chk("over_crash", int'(crash_a), 1);
    chk("over_score", int'({tens_a, ones_a}), 8'h07);
    cyc(1'b1, 1'b1, 8'b11100011, 8'b00001000);
    chk("restart_crash", int'(crash_a), 0);
    chk("restart_playing", int'(playing_a), 1);
    chk("restart_score", int'({tens_a, ones_a}), 0);
    clean_pass(8'b00001000);
    clean_pass(8'b00001000);

    // Asynchronous reset between edges
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_playing", int'(playing_a), 0);
    chk("async_crash", int'(crash_a), 0);
    chk("async_score", int'({tens_a, ones_a}), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b0, 1'b1, 8'b11100011, 8'b00001000);
    chk("post_reset_idle", int'(playing_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
